// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit MIPS datapath.
// Fetch/decode/exec/writeback/branch sequencing with a bounded imem wait.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       imem_ready,
  input  logic [1:0] opcode,
  input  logic       Zero,
  output logic       imem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic [2:0] ALUControl,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [7:0] WLAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    imem_req   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    ALUControl = 3'b000;
    halted     = 1'b0;
    fault      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            wait_d  = '0;
            state_d = S_DECODE;
          end else if (wait_q == WLAST) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      S_DECODE: begin
        unique case (opcode)
          2'b10:   state_d = S_BRANCH;
          2'b11:   state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ALUControl = ALU_ADD;
        ALUSrc     = (opcode == 2'b01);
        state_d    = S_WB;
      end
      // ALU inputs stay steered so ALUOut remains valid as WD
      S_WB: begin
        RegWrite   = 1'b1;
        ALUControl = ALU_ADD;
        ALUSrc     = (opcode == 2'b01);
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUControl = ALU_SUB;
        PCWrite    = Zero;
        PCSrc      = Zero;
        state_d    = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
    state = state_q;
    if (!reset) begin
      state_d    = S_FETCH;
      wait_d     = '0;
      imem_req   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      RegWrite   = 1'b0;
      ALUSrc     = 1'b0;
      ALUControl = 3'b000;
      halted     = 1'b0;
      fault      = 1'b0;
      state      = 3'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised + directed bench for multicycle_ctrl against
// an instruction-level behavioural model.
module tb_multicycle_ctrl;

  localparam int MAXW = 15;

  logic       clock;
  logic       reset;
  logic       run;
  logic       imem_ready;
  logic [1:0] opcode;
  logic       Zero;
  logic       imem_req;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       ALUSrc;
  logic [2:0] ALUControl;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  int passed = 0;
  int total  = 0;

  multicycle_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_ready(imem_ready), .opcode(opcode), .Zero(Zero),
    .imem_req(imem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .halted(halted), .fault(fault),
    .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: where in the instruction we are, and wait cycles spent.
  int ms = 0;
  int wc = 0;

  always @(posedge clock) begin
    if (!reset) begin
      ms = 0;
      wc = 0;
    end else if (ms == 0) begin
      if (run && imem_ready) begin
        ms = 1;
        wc = 0;
      end else if (run) begin
        wc = wc + 1;
        if (wc == MAXW) ms = 6;
      end
    end else if (ms == 1) begin
      ms = (opcode == 2'b10) ? 4 : (opcode == 2'b11) ? 5 : 2;
    end else if (ms == 2) begin
      ms = 3;
    end else if (ms == 3 || ms == 4) begin
      ms = 0;
    end
  end

  // {imem_req,IRWrite,PCWrite,PCSrc,RegWrite,ALUSrc,ALUControl,halted,fault,state}
  function automatic logic [13:0] expv();
    logic [13:0] v;
    logic fetch_go, addi;
    v = '0;
    if (!reset) return v;
    fetch_go = (ms == 0) && run && imem_ready;
    addi = (opcode == 2'b01);
    v[13] = (ms == 0) && run;
    v[12] = fetch_go;
    v[11] = fetch_go || (ms == 4 && Zero);
    v[10] = (ms == 4 && Zero);
    v[9]  = (ms == 3);
    v[8]  = (ms == 2 || ms == 3) && addi;
    if (ms == 2 || ms == 3) v[7:5] = 3'b010;
    if (ms == 4) v[7:5] = 3'b110;
    v[4] = (ms == 5);
    v[3] = (ms == 6);
    v[2:0] = 3'(ms);
    return v;
  endfunction

  always @(negedge clock) begin
    logic [13:0] got, exp;
    got = {imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc,
           ALUControl, halted, fault, state};
    exp = expv();
    total++;
    if (got === exp) passed++;
    else $display("FAIL cycle_cmp t=%0t got=%b exp=%b", $time, got, exp);
    total++;
    if (!(PCWrite && RegWrite)) passed++;
    else $display("FAIL excl t=%0t PCWrite=1 RegWrite=1 exp not both", $time);
  end

  task automatic cyc(input logic r, input logic ru, input logic rdy,
                     input logic [1:0] op, input logic z);
    reset = r; run = ru; imem_ready = rdy; opcode = op; Zero = z;
    @(posedge clock);
    #1;
  endtask

  task automatic pin(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", name, act, exp);
  endtask

  initial begin
    reset = 0; run = 0; imem_ready = 0; opcode = 0; Zero = 0;
    @(posedge clock); #1;
    cyc(0, 1, 1, 2'b00, 0);
    pin("reset_state", state, 0);
    // ADD: 0,1,2,3,0
    cyc(1, 1, 1, 2'b00, 0); pin("add_s1", state, 1); pin("add_m1", ms, 1);
    cyc(1, 0, 0, 2'b00, 0); pin("add_s2", state, 2);
    cyc(1, 0, 0, 2'b00, 0); pin("add_s3", state, 3);
    cyc(1, 0, 0, 2'b00, 0); pin("add_s0", state, 0);
    // ADDI
    cyc(1, 1, 1, 2'b01, 0);
    cyc(1, 0, 0, 2'b01, 0); pin("addi_alusrc", ALUSrc, 1);
    cyc(1, 0, 0, 2'b01, 0); pin("addi_wb", state, 3);
    cyc(1, 0, 0, 2'b01, 0);
    // BEQ taken and not taken: 3 cycles each
    cyc(1, 1, 1, 2'b10, 1);
    cyc(1, 0, 0, 2'b10, 1); pin("beq_state", state, 4);
    pin("beq_pcwrite", PCWrite, 1); pin("beq_alu", ALUControl, 6);
    cyc(1, 0, 0, 2'b10, 1); pin("beq_back", state, 0);
    cyc(1, 1, 1, 2'b10, 0);
    cyc(1, 0, 0, 2'b10, 0); pin("beqn_pcwrite", PCWrite, 0);
    cyc(1, 0, 0, 2'b10, 0); pin("beqn_back", state, 0);
    // HALT
    cyc(1, 1, 1, 2'b11, 0);
    cyc(1, 1, 1, 2'b11, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, $urandom_range(0, 3), 1);
    pin("halt_state", state, 5); pin("halt_flag", halted, 1);
    cyc(0, 1, 1, 2'b00, 0); pin("halt_reset", state, 0);
    // Bounded wait: fault after exactly MAXW cycles
    for (int i = 0; i < MAXW - 1; i++) cyc(1, 1, 0, 2'b00, 0);
    pin("wait_14", state, 0);
    cyc(1, 1, 0, 2'b00, 0);
    pin("fault_state", state, 6); pin("fault_flag", fault, 1);
    pin("fault_model", ms, 6);
    cyc(0, 0, 0, 2'b00, 0);
    // Ready on the last allowed cycle, then the counter must restart
    for (int i = 0; i < MAXW - 1; i++) cyc(1, 1, 0, 2'b00, 0);
    cyc(1, 1, 1, 2'b00, 0); pin("late_ready", state, 1);
    cyc(1, 0, 0, 2'b00, 0);
    cyc(1, 0, 0, 2'b00, 0);
    cyc(1, 0, 0, 2'b00, 0);
    for (int i = 0; i < MAXW - 1; i++) cyc(1, 1, 0, 2'b00, 0);
    pin("wait_restart", state, 0);
    cyc(1, 1, 1, 2'b00, 0);
    cyc(1, 0, 0, 2'b00, 0);
    cyc(1, 0, 0, 2'b00, 0); pin("pre_wb", state, 3);
    // Reset during WB
    reset = 0; #1;
    pin("wb_reset_regwrite", RegWrite, 0);
    @(posedge clock); #1;
    pin("wb_reset_state", state, 0);
    // Idle without run never faults
    for (int i = 0; i < 30; i++) cyc(1, 0, $urandom_range(0, 1), 2'b00, 0);
    pin("idle_fault", fault, 0); pin("idle_state", state, 0);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r;
      logic [1:0] op;
      r = ($urandom_range(0, (ms >= 5) ? 7 : 63) != 0);
      op = $urandom_range(0, 3);
      if (op == 2'b11 && $urandom_range(0, 3) != 0) op = 2'b00;
      cyc(r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          op, $urandom_range(0, 1));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
